// File: rtl/branch_predictor_if.sv
// Fetch/execute interface of the branch predictor.
// master = core side (drives PCs and resolution), slave = predictor.
// branch_op_e_i encoding: 2'b00 NON_BRANCH, 2'b01 JUMP, 2'b10 BRANCH, 2'b11 unused.
interface branch_predictor_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_f_i;
  logic            pred_taken_f_o;
  logic [PC_W-1:0] pc_e_i;
  logic [1:0]      branch_op_e_i;
  logic            pred_taken_e_i;
  logic            pc_src_res_e_i;
  logic            stall_e_i;
  logic            mispredict_e_o;
  logic [31:0]     branch_cnt_o;
  logic [31:0]     mispredict_cnt_o;

  modport master (
    output pc_f_i, pc_e_i, branch_op_e_i, pred_taken_e_i, pc_src_res_e_i, stall_e_i,
    input  pred_taken_f_o, mispredict_e_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  pc_f_i, pc_e_i, branch_op_e_i, pred_taken_e_i, pc_src_res_e_i, stall_e_i,
    output pred_taken_f_o, mispredict_e_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: 2**IDX_W two-bit saturating counters
// indexed by pc[IDX_W+1:2]. Fetch reads the table combinationally; execute
// trains it with the resolved direction and flags mispredictions.
// Optional macro BP_PERF_EN adds 32-bit branch/mispredict event counters;
// without it both counter outputs are tied to zero.
// branch_op encoding: 2'b00 NON_BRANCH, 2'b01 JUMP, 2'b10 BRANCH (2'b11 acts as NON_BRANCH).
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  branch_predictor_if.slave bp
);

  localparam int         DEPTH      = 1 << IDX_W;
  localparam logic [1:0] OP_JUMP    = 2'b01;
  localparam logic [1:0] OP_BRANCH  = 2'b10;
  localparam logic [1:0] CNT_WNT    = 2'b01;

  logic [1:0]       bht_q [DEPTH];
  logic [1:0]       bht_d [DEPTH];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic             upd;
  logic             is_ctrl;

  // Saturating +1/-1 step of a 2-bit direction counter.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    end
    return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
  endfunction

  // Index decode, lookup, update qualifier and mispredict flag.
  always_comb begin
    idx_f             = bp.pc_f_i[IDX_W+1:2];
    idx_e             = bp.pc_e_i[IDX_W+1:2];
    upd               = (bp.branch_op_e_i == OP_BRANCH) & ~bp.stall_e_i;
    is_ctrl           = (bp.branch_op_e_i == OP_BRANCH) | (bp.branch_op_e_i == OP_JUMP);
    // Lookup sees the registered value, so a same-cycle update is not bypassed.
    bp.pred_taken_f_o = bht_q[idx_f][1];
    bp.mispredict_e_o = is_ctrl & (bp.pred_taken_e_i != bp.pc_src_res_e_i);
  end

  // Next-state of the counter table: only the resolving entry moves.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (upd) begin
      bht_d[idx_e] = sat_step(bht_q[idx_e], bp.pc_src_res_e_i);
    end
  end

  // Counter table storage; reset returns every entry to weakly-not-taken.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= CNT_WNT;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] branch_cnt_d;
  logic [31:0] mispredict_cnt_q;
  logic [31:0] mispredict_cnt_d;

  // Event counters; natural 32-bit wrap, stalled cycles are not counted.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (bp.mispredict_e_o & ~bp.stall_e_i) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // Event counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branch_cnt_q     <= 32'h0;
      mispredict_cnt_q <= 32'h0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bp.branch_cnt_o     = branch_cnt_q;
  assign bp.mispredict_cnt_o = mispredict_cnt_q;
`else
  assign bp.branch_cnt_o     = 32'h0;
  assign bp.mispredict_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (IDX_W=6, PC_W=32).
module tb_branch_predictor;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_JUMP   = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_br;
  int   exp_mp;

  branch_predictor_if #(.PC_W(32)) bp ();

  branch_predictor #(.IDX_W(6), .PC_W(32)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bp      (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One execute-stage resolution, held for a single clock edge.
  task automatic resolve(input logic [31:0] pc, input logic [1:0] op,
                         input logic pred, input logic taken, input logic stall);
    bp.pc_e_i         = pc;
    bp.branch_op_e_i  = op;
    bp.pred_taken_e_i = pred;
    bp.pc_src_res_e_i = taken;
    bp.stall_e_i      = stall;
    tick();
    if (!stall) begin
      if (op == OP_BRANCH) exp_br++;
      if ((op == OP_BRANCH || op == OP_JUMP) && pred != taken) exp_mp++;
    end
    bp.branch_op_e_i  = OP_NONE;
    bp.stall_e_i      = 1'b0;
    bp.pred_taken_e_i = 1'b0;
    bp.pc_src_res_e_i = 1'b0;
    #1;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    bp.pc_f_i = pc;
    #1;
    check(tag, {31'h0, bp.pred_taken_f_o}, {31'h0, exp});
  endtask

  task automatic check_counts(input string tag);
`ifdef BP_PERF_EN
    check({tag, "_br"}, bp.branch_cnt_o, exp_br);
    check({tag, "_mp"}, bp.mispredict_cnt_o, exp_mp);
`else
    check({tag, "_br"}, bp.branch_cnt_o, 32'h0);
    check({tag, "_mp"}, bp.mispredict_cnt_o, 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    #1;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    exp_br            = 0;
    exp_mp            = 0;
    rst               = 1'b0;
    bp.pc_f_i         = 32'h0;
    bp.pc_e_i         = 32'h0;
    bp.branch_op_e_i  = OP_NONE;
    bp.pred_taken_e_i = 1'b0;
    bp.pc_src_res_e_i = 1'b0;
    bp.stall_e_i      = 1'b0;

    // 1. Reset state: every entry weakly not-taken.
    do_reset();
    pred_at("rst_pc40", 32'h40, 1'b0);
    for (int i = 0; i < 64; i++) begin
      pred_at($sformatf("rst_entry%0d", i), 32'(i) << 2, 1'b0);
    end
    check("rst_mispredict", {31'h0, bp.mispredict_e_o}, 32'h0);
    check_counts("rst_cnt");

    // 2. Training at 0x40: 01 -> 10 -> 11 -> 11 -> 11, then not-taken twice.
    resolve(32'h40, OP_BRANCH, 1'b0, 1'b1, 1'b0);
    pred_at("train_t1", 32'h40, 1'b1);
    resolve(32'h40, OP_BRANCH, 1'b1, 1'b1, 1'b0);
    pred_at("train_t2", 32'h40, 1'b1);
    resolve(32'h40, OP_BRANCH, 1'b1, 1'b1, 1'b0);
    resolve(32'h40, OP_BRANCH, 1'b1, 1'b1, 1'b0);
    pred_at("train_t4", 32'h40, 1'b1);
    resolve(32'h40, OP_BRANCH, 1'b1, 1'b0, 1'b0);
    pred_at("train_nt1", 32'h40, 1'b1);
    resolve(32'h40, OP_BRANCH, 1'b1, 1'b0, 1'b0);
    pred_at("train_nt2", 32'h40, 1'b0);
    pred_at("train_neighbour", 32'h44, 1'b0);

    // 3. Mispredict flag (combinational, no clock edge).
    bp.stall_e_i      = 1'b1;
    bp.branch_op_e_i  = OP_BRANCH;
    bp.pred_taken_e_i = 1'b1;
    bp.pc_src_res_e_i = 1'b0;
    #1 check("mp_branch", {31'h0, bp.mispredict_e_o}, 32'h1);
    bp.pc_src_res_e_i = 1'b1;
    #1 check("mp_branch_agree", {31'h0, bp.mispredict_e_o}, 32'h0);
    bp.branch_op_e_i  = OP_JUMP;
    bp.pred_taken_e_i = 1'b0;
    #1 check("mp_jump", {31'h0, bp.mispredict_e_o}, 32'h1);
    bp.branch_op_e_i  = OP_NONE;
    #1 check("mp_none", {31'h0, bp.mispredict_e_o}, 32'h0);
    bp.branch_op_e_i  = 2'b11;
    #1 check("mp_undef", {31'h0, bp.mispredict_e_o}, 32'h0);
    bp.branch_op_e_i  = OP_NONE;
    bp.stall_e_i      = 1'b0;
    bp.pred_taken_e_i = 1'b0;
    bp.pc_src_res_e_i = 1'b0;
    #1;

    // 4. Stall blocks update; JUMP never trains; aliasing 0x140 <-> 0x40.
    resolve(32'h40, OP_BRANCH, 1'b0, 1'b1, 1'b1);
    pred_at("stall_hold", 32'h40, 1'b0);
    resolve(32'h40, OP_BRANCH, 1'b0, 1'b1, 1'b0);
    pred_at("alias_140", 32'h140, 1'b1);
    resolve(32'h40, OP_JUMP, 1'b1, 1'b0, 1'b0);
    pred_at("jump_no_train", 32'h40, 1'b1);
    resolve(32'h140, OP_BRANCH, 1'b1, 1'b0, 1'b0);
    pred_at("alias_back", 32'h40, 1'b0);
    check_counts("mid_cnt");

    // 5. Same-entry read/write: pre-update value seen in the update cycle.
    resolve(32'h80, OP_BRANCH, 1'b0, 1'b1, 1'b0);
    bp.pc_f_i         = 32'h80;
    bp.pc_e_i         = 32'h80;
    bp.branch_op_e_i  = OP_BRANCH;
    bp.pred_taken_e_i = 1'b1;
    bp.pc_src_res_e_i = 1'b0;
    #1 check("same_cycle_pred", {31'h0, bp.pred_taken_f_o}, 32'h1);
    tick();
    exp_br++;
    exp_mp++;
    bp.branch_op_e_i  = OP_NONE;
    bp.pred_taken_e_i = 1'b0;
    #1 check("next_cycle_pred", {31'h0, bp.pred_taken_f_o}, 32'h0);
    check_counts("pre_reset_cnt");

    // Mid-training reset discards history (0x40 trained to WT above).
    resolve(32'h40, OP_BRANCH, 1'b0, 1'b1, 1'b0);
    pred_at("pre_reset_40", 32'h40, 1'b1);
    do_reset();
    pred_at("post_reset_40", 32'h40, 1'b0);
    check_counts("post_reset_cnt");
    resolve(32'h40, OP_BRANCH, 1'b0, 1'b1, 1'b0);
    pred_at("post_reset_wnt", 32'h40, 1'b1);

    // 6. Event counters: 10 branches, mispredicts at i=1,5,7, i=5 stalled.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      resolve(32'h200 + 32'(i) * 4, OP_BRANCH, (i == 1 || i == 5 || i == 7),
              1'b0, (i == 5));
    end
`ifdef BP_PERF_EN
    check("perf_br_total", bp.branch_cnt_o, 32'd9);
    check("perf_mp_total", bp.mispredict_cnt_o, 32'd2);
`else
    check("perf_br_off", bp.branch_cnt_o, 32'd0);
    check("perf_mp_off", bp.mispredict_cnt_o, 32'd0);
`endif
    do_reset();
    check("perf_br_cleared", bp.branch_cnt_o, 32'd0);
    check("perf_mp_cleared", bp.mispredict_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
